// File: rtl/calc_pkg.sv
// calc_pkg
// Shared definitions for the calculator input path:
//   - KEY_* : operator payloads carried in the low three bits of a 10ooo key token
//   - alu_op_e : opcode presented to the arithmetic unit
//   - seq_state_e : states of the input sequencer
package calc_pkg;

  localparam logic [2:0] KEY_ADD = 3'b000;
  localparam logic [2:0] KEY_SUB = 3'b001;
  localparam logic [2:0] KEY_MUL = 3'b010;
  localparam logic [2:0] KEY_DIV = 3'b011;
  localparam logic [2:0] KEY_EQ  = 3'b100;
  localparam logic [2:0] KEY_AC  = 3'b101;
  localparam logic [2:0] KEY_NEG = 3'b110;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_REQ,
    S_WAIT,
    S_ERR
  } seq_state_e;

endpackage

// File: rtl/decimal_append.sv
// decimal_append
// Combinational "type another digit" step for a signed decimal entry:
// result = value*10 + digit for non-negative values, value*10 - digit for
// negative ones, so the digit always extends the magnitude.
// Ports:
//   value    in  WIDTH  current two's-complement operand
//   digit    in  4      decimal digit 0..9
//   result   out WIDTH  low WIDTH bits of the appended value
//   in_range out 1      appended value fits the signed WIDTH range
module decimal_append #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] result,
  output logic             in_range
);

  // Four guard bits hold |value|*10 + 9 without wrapping.
  localparam int EW = WIDTH + 4;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] digit_ext;
  logic signed [EW-1:0] times10;
  logic signed [EW-1:0] sum;

  always_comb begin
    ext       = {{4{value[WIDTH-1]}}, value};
    digit_ext = {{(EW-4){1'b0}}, digit};
    times10   = (ext <<< 3) + (ext <<< 1);
    sum       = value[WIDTH-1] ? (times10 - digit_ext) : (times10 + digit_ext);
  end

  assign result = sum[WIDTH-1:0];
  // Fits when every bit above the WIDTH-bit sign position repeats the sign.
  assign in_range = (&sum[EW-1:WIDTH-1]) | ~(|sum[EW-1:WIDTH-1]);

endmodule

// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer
// Turns keypad tokens into signed decimal operands, issues requests to the
// arithmetic unit, folds results back into operand A and drives the display.
// Build option: define REPEAT_EQ_EN to let "=" after a result repeat the
// last operation with the last B operand.
// Ports:
//   clk, rst_n (async, active-low)
//   i_key_data/i_key_valid/o_key_ready : key token handshake
//                                        (0dddd digit, 10ooo operator)
//   o_alu_a/o_alu_b/o_alu_op/o_alu_valid/i_alu_ready : ALU request
//   i_alu_done/i_alu_result/i_alu_error : ALU response (done is a pulse)
//   o_disp_value/o_disp_err : registered display value and error flag
module calc_input_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_key_data,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_valid,
  input  logic             i_alu_ready,
  input  logic             i_alu_done,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_error,
  output logic [WIDTH-1:0] o_disp_value,
  output logic             o_disp_err
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  seq_state_e       state, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  alu_op_e          op_reg, op_next;
  alu_op_e          next_op_reg, next_op_next;
  logic             fresh_reg, fresh_next;
  logic             chain_reg, chain_next;
  logic [WIDTH-1:0] disp_value_reg, disp_value_next;
  logic             disp_err_reg, disp_err_next;
`ifdef REPEAT_EQ_EN
  logic [WIDTH-1:0] last_b_reg, last_b_next;
  alu_op_e          last_op_reg, last_op_next;
`endif

  logic             key_fire;
  logic             is_digit, is_op, is_arith, is_eq, is_ac, is_neg;
  logic [WIDTH-1:0] digit_value;
  logic [WIDTH-1:0] app_src, app_value;
  logic             app_ok;

  assign o_key_ready = (state != S_REQ) && (state != S_WAIT);
  assign key_fire    = i_key_valid && o_key_ready;

  // Digits 10..15, operator 111 and every 11xxx token decode to nothing and
  // are simply consumed.
  assign is_digit = !i_key_data[4] && (i_key_data[3:0] < 4'd10);
  assign is_op    = i_key_data[4] && !i_key_data[3];
  assign is_arith = is_op && (i_key_data[2:0] inside {KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV});
  assign is_eq    = is_op && (i_key_data[2:0] == KEY_EQ);
  assign is_ac    = is_op && (i_key_data[2:0] == KEY_AC);
  assign is_neg   = is_op && (i_key_data[2:0] == KEY_NEG);

  assign digit_value = {{(WIDTH-4){1'b0}}, i_key_data[3:0]};

  // One append unit serves both operands; only B is being typed in S_B.
  assign app_src = (state == S_B) ? b_reg : a_reg;

  decimal_append #(.WIDTH(WIDTH)) u_append (
    .value    (app_src),
    .digit    (i_key_data[3:0]),
    .result   (app_value),
    .in_range (app_ok)
  );

  // -MIN is not representable; hold MIN instead of wrapping.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (v == MIN_VAL) ? v : -v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_A;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= ALU_ADD;
      next_op_reg    <= ALU_ADD;
      fresh_reg      <= 1'b0;
      chain_reg      <= 1'b0;
      disp_value_reg <= '0;
      disp_err_reg   <= 1'b0;
`ifdef REPEAT_EQ_EN
      last_b_reg     <= '0;
      last_op_reg    <= ALU_ADD;
`endif
    end else begin
      state          <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      op_reg         <= op_next;
      next_op_reg    <= next_op_next;
      fresh_reg      <= fresh_next;
      chain_reg      <= chain_next;
      disp_value_reg <= disp_value_next;
      disp_err_reg   <= disp_err_next;
`ifdef REPEAT_EQ_EN
      last_b_reg     <= last_b_next;
      last_op_reg    <= last_op_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    a_next       = a_reg;
    b_next       = b_reg;
    op_next      = op_reg;
    next_op_next = next_op_reg;
    fresh_next   = fresh_reg;
    chain_next   = chain_reg;
`ifdef REPEAT_EQ_EN
    last_b_next  = last_b_reg;
    last_op_next = last_op_reg;
`endif

    if (key_fire && is_ac) begin
      state_next   = S_A;
      a_next       = '0;
      b_next       = '0;
      op_next      = ALU_ADD;
      next_op_next = ALU_ADD;
      fresh_next   = 1'b0;
      chain_next   = 1'b0;
`ifdef REPEAT_EQ_EN
      last_b_next  = '0;
      last_op_next = ALU_ADD;
`endif
    end else begin
      case (state)
        S_A: begin
          if (key_fire && is_digit) begin
            a_next     = fresh_reg ? digit_value : (app_ok ? app_value : a_reg);
            fresh_next = 1'b0;
          end else if (key_fire && is_neg) begin
            a_next = negate(a_reg);
          end else if (key_fire && is_arith) begin
            op_next    = alu_op_e'(i_key_data[1:0]);
            state_next = S_OP;
          end
`ifdef REPEAT_EQ_EN
          else if (key_fire && is_eq && fresh_reg) begin
            b_next     = last_b_reg;
            op_next    = last_op_reg;
            chain_next = 1'b0;
            state_next = S_REQ;
          end
`endif
        end
        S_OP: begin
          if (key_fire && is_digit) begin
            b_next     = digit_value;
            state_next = S_B;
          end else if (key_fire && is_neg) begin
            a_next = negate(a_reg);
          end else if (key_fire && is_arith) begin
            op_next = alu_op_e'(i_key_data[1:0]);
          end
        end
        S_B: begin
          if (key_fire && is_digit) begin
            b_next = app_ok ? app_value : b_reg;
          end else if (key_fire && is_neg) begin
            b_next = negate(b_reg);
          end else if (key_fire && is_arith) begin
            next_op_next = alu_op_e'(i_key_data[1:0]);
            chain_next   = 1'b1;
            state_next   = S_REQ;
          end else if (key_fire && is_eq) begin
            chain_next = 1'b0;
            state_next = S_REQ;
          end
        end
        S_REQ: begin
          if (i_alu_ready) begin
            state_next = S_WAIT;
`ifdef REPEAT_EQ_EN
            last_b_next  = b_reg;
            last_op_next = op_reg;
`endif
          end
        end
        S_WAIT: begin
          if (i_alu_done) begin
            if (i_alu_error) begin
              state_next = S_ERR;
            end else begin
              a_next = i_alu_result;
              b_next = '0;
              if (chain_reg) begin
                op_next    = next_op_reg;
                state_next = S_OP;
              end else begin
                fresh_next = 1'b1;
                state_next = S_A;
              end
            end
          end
        end
        default: begin
          // S_ERR: only AC (handled above) does anything.
        end
      endcase
    end

    // The display follows the state being entered, so it changes on the
    // same edge that consumes the token or the result.
    disp_err_next = (state_next == S_ERR);
    if (state_next == S_ERR) begin
      disp_value_next = '0;
    end else if (state_next == S_B) begin
      disp_value_next = b_next;
    end else begin
      disp_value_next = a_next;
    end
  end

  assign o_alu_valid  = (state == S_REQ);
  assign o_alu_a      = a_reg;
  assign o_alu_b      = b_reg;
  assign o_alu_op     = op_reg;
  assign o_disp_value = disp_value_reg;
  assign o_disp_err   = disp_err_reg;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// tb_calc_input_sequencer
// Directed scenarios for the calculator sequencer followed by a random key
// stream checked against a behavioural calculator model; the bench plays the
// ALU role itself.
module tb_calc_input_sequencer;

  localparam int W    = 16;
  localparam int MINV = -(1 << (W - 1));
  localparam int MAXV = (1 << (W - 1)) - 1;

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_SUB = 5'h11;
  localparam logic [4:0] K_MUL = 5'h12;
  localparam logic [4:0] K_DIV = 5'h13;
  localparam logic [4:0] K_EQ  = 5'h14;
  localparam logic [4:0] K_AC  = 5'h15;
  localparam logic [4:0] K_NEG = 5'h16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   i_key_data = '0;
  logic         i_key_valid = 1'b0;
  logic         o_key_ready;
  logic [W-1:0] o_alu_a, o_alu_b;
  logic [1:0]   o_alu_op;
  logic         o_alu_valid;
  logic         i_alu_ready = 1'b0;
  logic         i_alu_done = 1'b0;
  logic [W-1:0] i_alu_result = '0;
  logic         i_alu_error = 1'b0;
  logic [W-1:0] o_disp_value;
  logic         o_disp_err;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Calculator model: what the user has typed so far.
  // phase 0 = typing A, 1 = operator chosen, 2 = typing B.
  int ma, mb, mop, mnext, mphase, mlastb, mlastop;
  bit mfresh, mchain, merr;

  calc_input_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_key_data   (i_key_data),
    .i_key_valid  (i_key_valid),
    .o_key_ready  (o_key_ready),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_alu_valid  (o_alu_valid),
    .i_alu_ready  (i_alu_ready),
    .i_alu_done   (i_alu_done),
    .i_alu_result (i_alu_result),
    .i_alu_error  (i_alu_error),
    .o_disp_value (o_disp_value),
    .o_disp_err   (o_disp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int app(input int v, input int d);
    int n;
    n = (v >= 0) ? v * 10 + d : v * 10 - d;
    return (n < MINV || n > MAXV) ? v : n;
  endfunction

  function automatic int neg(input int v);
    return (v == MINV) ? MINV : -v;
  endfunction

  function automatic void alu_ref(input int a, input int b, input int op,
                                  output int res, output bit err);
    longint r;
    err = 1'b0;
    r   = 0;
    case (op)
      0: r = longint'(a) + b;
      1: r = longint'(a) - b;
      2: r = longint'(a) * b;
      default: if (b == 0) err = 1'b1; else r = longint'(a) / b;
    endcase
    if (r < MINV || r > MAXV) err = 1'b1;
    res = int'(r);
  endfunction

  task automatic model_clear();
    ma = 0; mb = 0; mop = 0; mnext = 0; mphase = 0;
    mfresh = 0; mchain = 0; merr = 0; mlastb = 0; mlastop = 0;
  endtask

  task automatic model_key(input logic [4:0] k, output bit req);
    int d, code;
    req  = 1'b0;
    d    = int'(k[3:0]);
    code = int'(k[2:0]);
    if (!k[4] && d > 9) return;
    if (k[4] && (k[3] || code == 7)) return;
    if (k == K_AC) begin model_clear(); return; end
    if (merr) return;
    if (!k[4]) begin
      if (mphase == 0) begin ma = mfresh ? d : app(ma, d); mfresh = 0; end
      else if (mphase == 1) begin mb = d; mphase = 2; end
      else mb = app(mb, d);
    end else if (k == K_NEG) begin
      if (mphase == 2) mb = neg(mb); else ma = neg(ma);
    end else if (code < 4) begin
      if (mphase == 0) begin mop = code; mphase = 1; end
      else if (mphase == 1) mop = code;
      else begin mnext = code; mchain = 1; req = 1'b1; end
    end else begin
      if (mphase == 2) begin mchain = 0; req = 1'b1; end
`ifdef REPEAT_EQ_EN
      else if (mphase == 0 && mfresh) begin mb = mlastb; mop = mlastop; mchain = 0; req = 1'b1; end
`endif
    end
    if (req) begin mlastb = mb; mlastop = mop; end
  endtask

  task automatic model_result(input int res, input bit err);
    if (err) merr = 1;
    else begin
      ma = res; mb = 0;
      if (mchain) begin mop = mnext; mphase = 1; end
      else begin mfresh = 1; mphase = 0; end
    end
  endtask

  function automatic int exp_disp();
    return merr ? 0 : ((mphase == 2) ? mb : ma);
  endfunction

  // Offer one token and wait (bounded) for it to be taken; returns on the
  // falling edge after the accepting edge.
  task automatic send_key(input logic [4:0] k);
    int n;
    n = 0;
    @(negedge clk);
    i_key_data  = k;
    i_key_valid = 1'b1;
    while (o_key_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("key_ready", o_key_ready, 1);
    @(negedge clk);
    i_key_valid = 1'b0;
  endtask

  task automatic press(input logic [4:0] k, input string tag, input int exp);
    send_key(k);
    check(tag, $signed(o_disp_value), exp);
  endtask

  // Act as the ALU for one request: check it, stall, accept, answer.
  task automatic serve_alu(input int ea, input int eb, input int eop,
                           input int rdly, input int ddly,
                           input int res, input bit err);
    for (int i = 0; i <= rdly; i++) begin
      if (i > 0) @(negedge clk);
      check("alu_valid", o_alu_valid, 1);
      check("alu_a", $signed(o_alu_a), ea);
      check("alu_b", $signed(o_alu_b), eb);
      check("alu_op", o_alu_op, eop);
      check("req_key_ready", o_key_ready, 0);
    end
    i_alu_ready = 1'b1;
    @(negedge clk);
    i_alu_ready = 1'b0;
    check("alu_valid_drop", o_alu_valid, 0);
    for (int i = 0; i < ddly; i++) begin
      @(negedge clk);
      check("wait_key_ready", o_key_ready, 0);
    end
    i_alu_result = res[W-1:0];
    i_alu_error  = err;
    i_alu_done   = 1'b1;
    @(negedge clk);
    i_alu_done  = 1'b0;
    i_alu_error = 1'b0;
  endtask

  initial begin
    logic [4:0] k;
    bit         req;
    bit         err;
    int         res;
    int         r;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_disp", $signed(o_disp_value), 0);
    check("rst_err", o_disp_err, 0);
    check("rst_valid", o_alu_valid, 0);
    check("rst_ready", o_key_ready, 1);

    // 12 + 34 = 46, then a new digit starts a fresh entry
    press(5'd1, "t1_d1", 1);
    press(5'd2, "t1_d2", 12);
    press(K_ADD, "t1_op", 12);
    press(5'd3, "t1_b1", 3);
    press(5'd4, "t1_b2", 34);
    press(K_EQ, "t1_eq", 12);
    serve_alu(12, 34, 0, 0, 1, 46, 1'b0);
    check("t1_res", $signed(o_disp_value), 46);
    press(5'd7, "t1_fresh", 7);
    press(K_AC, "t1_ac", 0);

    // Range limits on entry and negation
    press(5'd3, "t2_d1", 3);
    press(5'd2, "t2_d2", 32);
    press(5'd7, "t2_d3", 327);
    press(5'd6, "t2_d4", 3276);
    press(5'd7, "t2_d5", 32767);
    press(5'd8, "t2_drop_pos", 32767);
    press(K_NEG, "t2_neg", -32767);
    press(5'd8, "t2_drop_neg", -32767);
    press(5'hC, "t2_bad_digit", -32767);
    press(K_AC, "t2_ac", 0);

    // Chained operator: 5 * 6 -> 30, then 30 - 2
    press(5'd5, "t3_a", 5);
    press(K_MUL, "t3_mul", 5);
    press(5'd6, "t3_b", 6);
    press(K_SUB, "t3_chain", 5);
    serve_alu(5, 6, 2, 1, 0, 30, 1'b0);
    check("t3_res", $signed(o_disp_value), 30);
    press(5'd2, "t3_b2", 2);
    press(K_EQ, "t3_eq", 30);
    serve_alu(30, 2, 1, 0, 0, 28, 1'b0);
    check("t3_res2", $signed(o_disp_value), 28);
    press(K_AC, "t3_ac", 0);

    // Divide by zero -> error, only AC recovers
    press(5'd9, "t4_a", 9);
    press(K_DIV, "t4_div", 9);
    press(5'd0, "t4_b", 0);
    press(K_EQ, "t4_eq", 9);
    serve_alu(9, 0, 3, 0, 0, 0, 1'b1);
    check("t4_err", o_disp_err, 1);
    check("t4_err_disp", $signed(o_disp_value), 0);
    press(5'd4, "t4_drop", 0);
    check("t4_err_hold", o_disp_err, 1);
    press(K_AC, "t4_ac", 0);
    check("t4_err_clr", o_disp_err, 0);

    // Stalled request with AC offered: AC waits for the result
    press(5'd1, "t5_a", 1);
    press(K_ADD, "t5_op", 1);
    press(5'd2, "t5_b", 2);
    press(K_EQ, "t5_eq", 1);
    i_key_data  = K_AC;
    i_key_valid = 1'b1;
    serve_alu(1, 2, 0, 3, 2, 3, 1'b0);
    check("t5_ac_held", $signed(o_disp_value), 3);
    @(negedge clk);
    i_key_valid = 1'b0;
    check("t5_ac_taken", $signed(o_disp_value), 0);

    // Reset while a request is pending drops valid at once
    press(5'd4, "t6_a", 4);
    press(K_ADD, "t6_op", 4);
    press(5'd5, "t6_b", 5);
    press(K_EQ, "t6_eq", 4);
    check("t6_valid", o_alu_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", o_alu_valid, 0);
    check("t6_async_disp", $signed(o_disp_value), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during the wait; the late result must be ignored
    press(5'd4, "t7_a", 4);
    press(K_ADD, "t7_op", 4);
    press(5'd5, "t7_b", 5);
    press(K_EQ, "t7_eq", 4);
    i_alu_ready = 1'b1;
    @(negedge clk);
    i_alu_ready = 1'b0;
    check("t7_wait_ready", o_key_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_ready", o_key_ready, 1);
    check("t7_rst_disp", $signed(o_disp_value), 0);
    @(negedge clk);
    rst_n        = 1'b1;
    i_alu_result = 16'd99;
    i_alu_done   = 1'b1;
    @(negedge clk);
    i_alu_done = 1'b0;
    check("t7_done_ignored", $signed(o_disp_value), 0);
    check("t7_no_valid", o_alu_valid, 0);
    press(5'd6, "t7_after", 6);

    // Random key stream against the model
    model_clear();
    press(K_AC, "rnd_start", 0);
    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50)      k = 5'($urandom_range(0, 9));
      else if (r < 85) k = 5'($urandom_range(16, 20));
      else if (r < 90) k = K_NEG;
      else if (r < 94) k = K_AC;
      else             k = 5'($urandom_range(0, 31));
      model_key(k, req);
      send_key(k);
      if (req) begin
        check("rnd_req_disp", $signed(o_disp_value), ma);
        alu_ref(ma, mb, mop, res, err);
        serve_alu(ma, mb, mop, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), res, err);
        model_result(res, err);
      end
      check("rnd_disp", $signed(o_disp_value), exp_disp());
      check("rnd_err", o_disp_err, merr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
